// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel synchroniser, selectable edge detect,
// retriggerable pulse extender, sticky status and masked registered irq.
// Optional stability filter between synchroniser and detector is enabled by
// defining MULTI_EDGE_DETECTOR_DEBOUNCE_EN.
module multi_edge_detector #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned PULSE_EXT       = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     signal_in,
    input  logic [2*NUM_CH-1:0]   edge_sel,
    input  logic [NUM_CH-1:0]     status_clr,
    input  logic [NUM_CH-1:0]     irq_mask,
    output logic [NUM_CH-1:0]     pulse_out,
    output logic [NUM_CH-1:0]     edge_status,
    output logic                  irq
);

    if (NUM_CH < 1 || NUM_CH > 32 || SYNC_STAGES < 1 || SYNC_STAGES > 4 ||
        PULSE_EXT < 1 || PULSE_EXT > 255 ||
        DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_param_check
        $error("multi_edge_detector: parameter out of range");
    end

    localparam logic [7:0] EXT_LOAD = 8'(PULSE_EXT);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] f;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] det;
    logic [7:0]        cnt_q [NUM_CH];
    logic [9:0]        warm_q;
    logic              armed;

    // Synchroniser chain; the last stage is the clean sampled level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= signal_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
    localparam logic [7:0]  DB_LIMIT  = 8'(DEBOUNCE_CYCLES);
    localparam int unsigned ARM_DELAY = SYNC_STAGES + DEBOUNCE_CYCLES;

    logic [7:0]        db_cnt_q [NUM_CH];
    logic [NUM_CH-1:0] filt_q;

    // Stability filter: f follows s only after DEBOUNCE_CYCLES mismatching cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (s[i] != filt_q[i]) begin
                    if (db_cnt_q[i] == DB_LIMIT - 8'd1) begin
                        filt_q[i]   <= s[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign f = filt_q;
`else
    localparam int unsigned ARM_DELAY = SYNC_STAGES;

    assign f = s;
`endif

    localparam logic [9:0] ARM_AT = 10'(ARM_DELAY);

    // Arming waits until the reset zeros have drained out of the synchroniser
    // (and filter), so a level already high at release becomes the baseline
    // in prev instead of looking like a fresh rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q <= '0;
            armed  <= 1'b0;
        end else if (!armed) begin
            if (warm_q == ARM_AT) begin
                armed <= 1'b1;
            end else begin
                warm_q <= warm_q + 10'd1;
            end
        end
    end

    // Previous filtered level, tracked every cycle regardless of mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= f;
        end
    end

    // Edge detect against the current per-channel mode.
    always_comb begin
        det = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            case (edge_sel[2*i +: 2])
                2'b01:   det[i] = armed &&  f[i] && !prev_q[i];
                2'b10:   det[i] = armed && !f[i] &&  prev_q[i];
                2'b11:   det[i] = armed && (f[i] != prev_q[i]);
                default: det[i] = 1'b0;
            endcase
        end
    end

    // Retriggerable pulse extender; mode off kills an active pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (edge_sel[2*i +: 2] == 2'b00) begin
                    cnt_q[i] <= '0;
                end else if (det[i]) begin
                    cnt_q[i] <= EXT_LOAD;
                end else if (cnt_q[i] != 8'd0) begin
                    cnt_q[i] <= cnt_q[i] - 8'd1;
                end
            end
        end
    end

    // Pulse is active while the extender counter is non-zero.
    always_comb begin
        pulse_out = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pulse_out[i] = (cnt_q[i] != 8'd0);
        end
    end

    // Sticky status (set beats clear) and registered masked interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_status <= '0;
            irq         <= 1'b0;
        end else begin
            edge_status <= (edge_status & ~status_clr) | det;
            irq         <= |(edge_status & irq_mask);
        end
    end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: a per-cycle vector table on a
// PULSE_EXT=1 instance plus directed sequences on PULSE_EXT=5 and 10 instances.
module tb_multi_edge_detector;

`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int NV    = 34;
    localparam int NROWS = 28 + DB;

    logic clk;
    int   checks;
    int   failures;

    logic       a_rst, b_rst, c_rst;
    logic [3:0] a_sig, a_clr, a_mask, a_pulse, a_status;
    logic [7:0] a_sel;
    logic       a_irq;
    logic [3:0] b_sig, b_clr, b_mask, b_pulse, b_status;
    logic [7:0] b_sel;
    logic       b_irq;
    logic [3:0] c_sig, c_clr, c_mask, c_pulse, c_status;
    logic [7:0] c_sel;
    logic       c_irq;

    typedef struct {
        logic [3:0] sig;
        logic [7:0] sel;
        logic [3:0] clr;
        logic [3:0] mask;
        logic [3:0] pulse;
        logic [3:0] status;
        logic       irq;
    } vec_t;

    vec_t vec [NV];

    multi_edge_detector #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_EXT(1), .DEBOUNCE_CYCLES(4)) u_a (
        .clk(clk), .rst_n(a_rst), .signal_in(a_sig), .edge_sel(a_sel), .status_clr(a_clr),
        .irq_mask(a_mask), .pulse_out(a_pulse), .edge_status(a_status), .irq(a_irq));

    multi_edge_detector #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_EXT(5), .DEBOUNCE_CYCLES(4)) u_b (
        .clk(clk), .rst_n(b_rst), .signal_in(b_sig), .edge_sel(b_sel), .status_clr(b_clr),
        .irq_mask(b_mask), .pulse_out(b_pulse), .edge_status(b_status), .irq(b_irq));

    multi_edge_detector #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_EXT(10), .DEBOUNCE_CYCLES(4)) u_c (
        .clk(clk), .rst_n(c_rst), .signal_in(c_sig), .edge_sel(c_sel), .status_clr(c_clr),
        .irq_mask(c_mask), .pulse_out(c_pulse), .edge_status(c_status), .irq(c_irq));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive b_sig[ch] high on rows [rise, fall) and profile pulse_out[ch].
    task automatic b_window(input int ch, input int rise, input int fall, input int nrows,
                            output int hi, output int segs, output int first);
        logic last;
        hi = 0; segs = 0; first = -1; last = 1'b0;
        for (int r = 0; r < nrows; r++) begin
            b_sig[ch] = (r >= rise && r < fall);
            step();
            if (b_pulse[ch]) begin
                hi++;
                if (!last) segs++;
                if (first < 0) first = r;
            end
            last = b_pulse[ch];
        end
    endtask

    initial begin
        int hi, segs, first;
        logic found;
        checks   = 0;
        failures = 0;

        for (int t = 0; t < NROWS; t++) begin
            vec[t].sig[0]    = (t >= 4);
            vec[t].sig[1]    = !(t >= 10 && t < 14);
            vec[t].sig[2]    = (t >= 20);
            vec[t].sig[3]    = (t < 16);
            vec[t].sel       = 8'b10_11_01_01;
            vec[t].mask      = 4'b0101;
            vec[t].clr       = 4'b0000;
            vec[t].clr[0]    = (t == 12 + DB);
            vec[t].clr[2]    = (t == 22 + DB) || (t == 23 + DB);
            vec[t].pulse[0]  = (t == 6 + DB);
            vec[t].pulse[1]  = (t == 16 + DB);
            vec[t].pulse[2]  = (t == 22 + DB);
            vec[t].pulse[3]  = (t == 18 + DB);
            vec[t].status[0] = (t >= 6 + DB && t < 12 + DB);
            vec[t].status[1] = (t >= 16 + DB);
            vec[t].status[2] = (t == 22 + DB);
            vec[t].status[3] = (t >= 18 + DB);
            vec[t].irq       = (t >= 7 + DB && t < 13 + DB) || (t == 23 + DB);
        end

        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_sig = 4'b1010; a_sel = 8'b10_11_01_01; a_clr = '0; a_mask = 4'b0101;
        b_sig = '0; b_sel = 8'b00_00_01_11; b_clr = '0; b_mask = '0;
        c_sig = '0; c_sel = 8'b01_00_00_00; c_clr = '0; c_mask = '0;
        step();
        step();
        chk("rst_a_pulse",  32'(a_pulse), 0);
        chk("rst_a_status", 32'(a_status), 0);
        chk("rst_a_irq",    32'(a_irq), 0);
        chk("rst_b_pulse",  32'(b_pulse), 0);
        chk("rst_c_status", 32'(c_status), 0);
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;

        for (int t = 0; t < NROWS; t++) begin
            a_sig  = vec[t].sig;
            a_sel  = vec[t].sel;
            a_clr  = vec[t].clr;
            a_mask = vec[t].mask;
            step();
            chk($sformatf("a_pulse[%0d]", t),  32'(a_pulse),  32'(vec[t].pulse));
            chk($sformatf("a_status[%0d]", t), 32'(a_status), 32'(vec[t].status));
            chk($sformatf("a_irq[%0d]", t),    32'(a_irq),    32'(vec[t].irq));
        end

        // Both mode, rise then fall 3 cycles later: one merged pulse of 3+5.
        b_window(0, 0, 3, 20, hi, segs, first);
        chk("b_merge_hi",    hi,    (DB != 0) ? 0 : 8);
        chk("b_merge_segs",  segs,  (DB != 0) ? 0 : 1);
        chk("b_merge_first", first, (DB != 0) ? -1 : 2);
        chk("b_merge_status", 32'(b_status[0]), (DB != 0) ? 0 : 1);
        b_clr = 4'b0001;
        step();
        b_clr = '0;
        chk("b_clr_status", 32'(b_status[0]), 0);

        // One-cycle glitch in both mode: two dets merge into 1+5 cycles.
        b_window(0, 0, 1, 12, hi, segs, first);
        chk("b_glitch_hi",   hi,   (DB != 0) ? 0 : 6);
        chk("b_glitch_segs", segs, (DB != 0) ? 0 : 1);

        // Six-cycle high on a rising-mode channel: one pulse, filter adds DB.
        b_window(1, 0, 6, 20, hi, segs, first);
        chk("b_level_hi",    hi,    5);
        chk("b_level_segs",  segs,  1);
        chk("b_level_first", first, 2 + DB);

        // Asynchronous reset mid-pulse, then re-arm with the level held high.
        b_sig[1] = 1'b1;
        found = 1'b0;
        for (int r = 0; r < 12 && !found; r++) begin
            step();
            found = b_pulse[1];
        end
        chk("b_arst_pulse_seen", 32'(found), 1);
        #2;
        b_rst = 1'b0;
        #1;
        chk("b_arst_pulse",  32'(b_pulse), 0);
        chk("b_arst_status", 32'(b_status), 0);
        step();
        step();
        b_rst = 1'b1;
        hi = 0;
        for (int r = 0; r < 14; r++) begin
            step();
            if (b_pulse != 4'b0000) hi++;
        end
        chk("b_rearm_quiet", hi, 0);

        // Mode switched off three cycles into a 10-cycle pulse.
        c_sig[3] = 1'b1;
        found = 1'b0;
        for (int r = 0; r < 12 && !found; r++) begin
            step();
            found = c_pulse[3];
        end
        chk("c_pulse_seen", 32'(found), 1);
        step();
        chk("c_hold2", 32'(c_pulse[3]), 1);
        step();
        chk("c_hold3", 32'(c_pulse[3]), 1);
        c_sel = 8'b00_00_00_00;
        step();
        chk("c_off_pulse",  32'(c_pulse[3]), 0);
        chk("c_off_status", 32'(c_status[3]), 1);
        step();
        step();
        c_sel = 8'b01_00_00_00;
        hi = 0;
        for (int r = 0; r < 15; r++) begin
            step();
            if (c_pulse[3]) hi++;
        end
        chk("c_reenable_quiet", hi, 0);

        // Fresh fall/rise after re-enable gives a full 10-cycle pulse.
        c_sig[3] = 1'b0;
        for (int r = 0; r < 8; r++) step();
        c_sig[3] = 1'b1;
        found = 1'b0;
        for (int r = 0; r < 12 && !found; r++) begin
            step();
            found = c_pulse[3];
        end
        chk("c_fresh_seen", 32'(found), 1);
        hi = found ? 1 : 0;
        for (int r = 0; r < 15 && found; r++) begin
            step();
            if (c_pulse[3]) hi++;
            else found = 1'b0;
        end
        chk("c_fresh_len", hi, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
